// File: rtl/code_pkg.sv
// code_pkg: shared FSM states, mode constants and code-index width helper
package code_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_CYCLE  = 2'b01;
    localparam logic [1:0] MODE_INV    = 2'b10;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/code_sequencer_chip_timer.sv
// chip_timer: counts clk cycles within one code bit and ticks on the last one
module chip_timer #(
    parameter int NB_REG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [NB_REG-1:0] width,
    output logic              tick
);
    logic [NB_REG-1:0] cnt;
    assign tick = enable && cnt == width - NB_REG'(1);
    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + NB_REG'(1);
    end
endmodule

// File: rtl/code_sequencer.sv
// code_sequencer: transmits a stored code word chip by chip on each sinc window
module code_sequencer
    import code_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_CODE = 64,
    parameter int N_CODES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sinc,
    input  logic [1:0]                   modo,
    input  logic [NB_REG-1:0]            num_dig,
    input  logic [NB_REG-1:0]            tiempo_b,
    input  logic [N_CODES*NB_CODE-1:0]   codigos,
    output logic                         out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [idx_w(N_CODES)-1:0]    code_idx
);
    localparam int IW = idx_w(N_CODES);
    localparam int BW = $clog2(NB_CODE + 1);
    state_t state, state_n;
    logic sinc_r, start, valid, tick, last, inv_sh, cyc_sh;
    logic [NB_CODE-1:0] word_sh;
    logic [NB_CODE-1:0] bank [N_CODES];
    logic [NB_REG-1:0] tb_sh;
    logic [BW-1:0] bit_cnt, last_sh;
    logic [IW-1:0] sel;
    for (genvar g = 0; g < N_CODES; g++) begin : g_bank
        assign bank[g] = codigos[g*NB_CODE +: NB_CODE];
    end
    assign start = sinc && !sinc_r;
    assign valid = num_dig != '0 && num_dig <= NB_REG'(NB_CODE) && tiempo_b != '0;
    assign last  = bit_cnt == last_sh;
    assign sel   = modo == MODE_CYCLE ? code_idx : '0;
    chip_timer #(.NB_REG(NB_REG)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != RUN),
        .enable (state == RUN),
        .width  (tb_sh),
        .tick   (tick)
    );
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_comb begin
        state_n   = state;
        out       = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (state == IDLE) state_n = start ? (valid ? RUN : HOLD) : IDLE;
        if (state == HOLD) state_n = sinc ? HOLD : IDLE;
        if (state == RUN) begin
            state_n   = !sinc ? IDLE : (tick && last) ? HOLD : RUN;
            out       = word_sh[0] ^ inv_sh;
            out_valid = 1'b1;
            busy      = 1'b1;
        end
    end
    // shadow registers freeze the configuration for the whole pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sinc_r   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            code_idx <= '0;
            word_sh  <= '0;
            tb_sh    <= '0;
            last_sh  <= '0;
            bit_cnt  <= '0;
            inv_sh   <= 1'b0;
            cyc_sh   <= 1'b0;
        end else begin
            sinc_r <= sinc;
            done   <= state == RUN && sinc && tick && last;
            err    <= state == IDLE && start && !valid;
            if (state == IDLE && start && valid) begin
                word_sh <= bank[sel];
                tb_sh   <= tiempo_b;
                last_sh <= BW'(num_dig - NB_REG'(1));
                bit_cnt <= '0;
                inv_sh  <= modo == MODE_INV;
                cyc_sh  <= modo == MODE_CYCLE;
                if (modo != MODE_CYCLE) code_idx <= '0;
            end else if (state == RUN && tick) begin
                word_sh <= word_sh >> 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == RUN && sinc && tick && last && cyc_sh)
                code_idx <= code_idx == IW'(N_CODES - 1) ? '0 : code_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_code_sequencer.sv
// tb_code_sequencer: directed and random pulses checked against a chip-list model
module tb_code_sequencer;
    logic clk = 1'b0;
    logic rst, sinc;
    logic [1:0] modo;
    logic [31:0] num_dig, tiempo_b;
    logic [127:0] codigos;
    logic out, out_valid, busy, done, err;
    logic [0:0] code_idx;
    int checks = 0;
    int errors = 0;
    int midx = 0;
    logic [63:0] words [2];

    always #5 clk = ~clk;

    code_sequencer dut (
        .clk(clk), .rst(rst), .sinc(sinc), .modo(modo), .num_dig(num_dig),
        .tiempo_b(tiempo_b), .codigos(codigos), .out(out), .out_valid(out_valid),
        .busy(busy), .done(done), .err(err), .code_idx(code_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int idx);
        chk({tag, ".out"}, 64'(out), 64'd0);
        chk({tag, ".valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
        chk({tag, ".idx"}, 64'(code_idx), 64'(idx));
    endtask

    task automatic scramble();
        modo     = 2'($urandom_range(0, 3));
        num_dig  = $urandom_range(0, 100);
        tiempo_b = $urandom_range(0, 5);
        codigos  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // one sinc window of win cycles; the expected chip at cycle c is bit c/t of the word
    task automatic pulse(input logic [1:0] m, input int n, input int t, input int win);
        int idx0, len;
        logic inv;
        logic [63:0] w;
        idx0 = (m == 2'd1) ? midx : 0;
        w    = words[idx0];
        inv  = (m == 2'd2);
        len  = n * t;
        midx = idx0;
        modo = m; num_dig = n; tiempo_b = t; codigos = {words[1], words[0]};
        sinc = 1'b1;
        for (int c = 0; c < win; c++) begin
            tick();
            scramble();
            if (c < len) begin
                chk("run.out", 64'(out), 64'(w[c / t] ^ inv));
                chk("run.valid", 64'(out_valid), 64'd1);
                chk("run.busy", 64'(busy), 64'd1);
                chk("run.done", 64'(done), 64'd0);
                chk("run.idx", 64'(code_idx), 64'(idx0));
            end else begin
                if (c == len && m == 2'd1) midx = (idx0 + 1) % 2;
                chk("end.out", 64'(out), 64'd0);
                chk("end.valid", 64'(out_valid), 64'd0);
                chk("end.busy", 64'(busy), 64'd0);
                chk("end.done", 64'(done), 64'(c == len));
                chk("end.idx", 64'(code_idx), 64'(midx));
            end
        end
        sinc = 1'b0;
        tick();
        chk_quiet("drop", midx);
        tick();
    endtask

    task automatic bad(input int n, input int t);
        modo = 2'd0; num_dig = n; tiempo_b = t;
        sinc = 1'b1;
        tick();
        chk("bad.err", 64'(err), 64'd1);
        chk("bad.out", 64'(out), 64'd0);
        chk("bad.busy", 64'(busy), 64'd0);
        chk("bad.valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("bad.hold", midx);
        end
        sinc = 1'b0;
        tick();
        chk_quiet("bad.idle", midx);
        tick();
    endtask

    initial begin
        rst = 1'b1; sinc = 1'b0; modo = 2'd0; num_dig = 0; tiempo_b = 0; codigos = '0;
        tick();
        tick();
        chk_quiet("reset", 0);
        sinc = 1'b1; num_dig = 5; tiempo_b = 3;
        tick();
        chk("rst_start.busy", 64'(busy), 64'd0);
        rst = 1'b0; sinc = 1'b0;
        tick();
        chk_quiet("rst_start", 0);
        words[0] = 64'b10110; words[1] = {$urandom, $urandom};
        pulse(2'd0, 5, 3, 40);
        words[0] = 64'b01;
        pulse(2'd2, 2, 3, 10);
        words[0] = {$urandom, $urandom}; words[1] = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) pulse(2'd1, 6, 2, 15);
        chk("cycle.idx", 64'(midx), 64'd1);
        pulse(2'd1, 5, 3, 4);
        bad(0, 3);
        bad(5, 0);
        bad(65, 2);
        pulse(2'd0, 3, 2, 10);
        modo = 2'd1; num_dig = 64; tiempo_b = 1; codigos = {words[1], words[0]};
        sinc = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rstmid.out", 64'(out), 64'(words[midx][c]));
        end
        rst = 1'b1; sinc = 1'b0;
        tick();
        chk_quiet("rstmid", 0);
        rst = 1'b0; midx = 0;
        tick();
        pulse(2'd1, 64, 1, 70);
        for (int i = 0; i < 25; i++) begin
            int n, t, len, win;
            n = ($urandom_range(0, 4) == 0) ? 64 : $urandom_range(1, 12);
            t = $urandom_range(1, 3);
            len = n * t;
            win = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : len + $urandom_range(1, 4);
            words[0] = {$urandom, $urandom}; words[1] = {$urandom, $urandom};
            pulse(2'($urandom_range(0, 3)), n, t, win);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 The block SHALL have parameter NB_REG, default 32, meaning width of the configuration words num_dig and tiempo_b.
REQ-002 The block SHALL have parameter NB_CODE, default 64, meaning the maximum code length in bits.
REQ-003 The block SHALL have parameter N_CODES, default 2, meaning the number of stored code words; legal range is 1..16.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- sinc  in  1  transmit window; a rising edge starts one pulse.
- modo  in  2  sequencing mode: 00 single, 01 cycle, 10 single-inverted, 11 reserved (acts as 00).
- num_dig  in  NB_REG  number of code bits per pulse.
- tiempo_b  in  NB_REG  bit width in clk cycles.
- codigos  in  N_CODES*NB_CODE  flat code bank; word k is bits [k*NB_CODE +: NB_CODE], and bit 0 is transmitted first.
- out  out  1  code chip output.
- out_valid  out  1  high while a chip is being driven.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal end of pulse.
- err  out  1  one-cycle pulse on rejected start.
- code_idx  out  clog2(N_CODES) (minimum 1)  index of the word in use or next to be used.

Function
REQ-005 sinc SHALL be registered once; a start condition SHALL be sinc=1 with the previous registered sinc=0.
REQ-006 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-007 From IDLE, on a start with 1<=num_dig<=NB_CODE and tiempo_b>=1, the block SHALL latch num_dig, tiempo_b, modo and the selected code word into shadow registers and enter RUN.
REQ-008 From IDLE, on a start with num_dig=0, num_dig>NB_CODE or tiempo_b=0, the block SHALL pulse err for one cycle, enter HOLD, and leave out low.
REQ-009 In RUN, out SHALL present the current bit of the latched word, XOR 1 in mode 10, for exactly tiempo_b cycles per bit, with out_valid=1.
REQ-010 The first chip SHALL appear on out on the cycle after the clock edge that detected the start, giving 1 cycle of latency from the registered start.
REQ-011 After bit num_dig-1 completes its tiempo_b cycles, the block SHALL pulse done for one cycle, drive out and out_valid to 0, and enter HOLD.
REQ-012 In HOLD, out SHALL be 0 and the block SHALL return to IDLE when sinc=0; a pulse SHALL never restart while sinc stays high.
REQ-013 If sinc falls during RUN, the block SHALL abort: it SHALL go to IDLE on the next edge with out=0, out_valid=0 and no done pulse, and code_idx SHALL be unchanged.
REQ-014 In mode 01, code_idx SHALL advance by 1 on each done pulse and wrap from N_CODES-1 to 0; in modes 00, 10 and 11 it SHALL stay at 0, so word 0 is used.
REQ-015 Changes to any configuration input during RUN SHALL have no effect until the next start.
REQ-016 The bit-time counter SHALL be NB_REG wide and the bit counter SHALL be clog2(NB_CODE+1) wide; comparisons SHALL be unsigned and no counter SHALL wrap within a legal pulse.
REQ-017 If a start and reset occur in the same cycle, reset SHALL win.

Reset
REQ-018 When rst=1 at a clk edge, the block SHALL enter IDLE and SHALL clear out, out_valid, busy, done, err, code_idx, all counters, all shadow registers and the registered sinc.
REQ-019 Reset asserted mid-pulse SHALL terminate the pulse with out=0 from the following cycle, with no done pulse.

Structure
REQ-020 The state encoding, the mode constants (MODE_SINGLE, MODE_CYCLE, MODE_INV) and the code-index width function SHALL reside in a shared package code_pkg.
REQ-021 The per-bit timing counter SHALL be a sub-module named chip_timer, with inputs clear, enable and width, and a one-cycle output tick at the end of each bit.

Verification
REQ-022 The bench SHALL drive mode 00, num_dig=5, tiempo_b=3, word0=0b10110 and sinc high for 40 cycles, and SHALL see out = 0,0,0,1,1,1,1,1,1,0,0,0,1,1,1 followed by a done pulse and then out=0 for the rest of the window.
REQ-023 The bench SHALL drive mode 01, N_CODES=2, three complete pulses, and SHALL see code_idx = 0, 1, 0 on the successive pulses, each pulse transmitting the matching word.
REQ-024 The bench SHALL drop sinc after 4 cycles of a 15-cycle pulse, and SHALL see out=0 on the next cycle, no done pulse, and code_idx unchanged.
REQ-025 The bench SHALL drive num_dig=0 and, separately, tiempo_b=0 at a start, and SHALL see an err pulse, out held at 0, and the block back in IDLE after sinc falls.
REQ-026 The bench SHALL drive mode 10 with word 0b01 and num_dig=2, and SHALL see out=0 for tiempo_b cycles then out=1 for tiempo_b cycles.
REQ-027 The bench SHALL assert rst mid-pulse with num_dig=NB_CODE, and SHALL see all outputs at 0 on the next cycle and a clean restart on the following sinc rising edge.
